pipeline_ctrl: RTL
==================

# pipeline_ctrl

Stall/flush controller for the 5-stage RV32I pipeline. It handles the hazards that the bypass network cannot resolve: load-use dependences, outstanding instruction/data memory responses, and taken-branch redirects. It tracks in-flight memory requests, freezes or bubbles pipeline registers, and discards wrong-path fetch responses. It sits beside the forwarding logic and drives the enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023, maximum consecutive non-IDLE cycles before `timeout_err` sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- id_rs1_s, id_rs2_s  in  5  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- ex_rd_s  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  the EX instruction is a load.
- ex_br_taken  in  1  EX resolved a redirect (taken branch or jump).
- imem_req, imem_resp  in  1  fetch issued this cycle / fetch data returned.
- dmem_req, dmem_resp  in  1  MEM access issued this cycle / data returned.
- stall_if, stall_id  out  1  hold the PC and IF/ID register.
- stall_ex, stall_mem  out  1  hold the ID/EX and EX/MEM registers.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  replace the IF/ID contents with a NOP.
- imem_discard  out  1  drop the current `imem_resp` (wrong path).
- timeout_err  out  1  sticky watchdog error.
- perf_stall_cnt, perf_loaduse_cnt  out  32 each  present only with `PIPE_CTRL_PERF_EN`.

## Operation
- Outstanding trackers, one each for imem and dmem:
  - Set on `req`, clear on `resp`.
  - When `req` and `resp` occur in the same cycle, the tracker stays set.
  - `resp` with nothing outstanding is ignored.
- FSM states: IDLE, WAIT_IMEM, WAIT_DMEM, WAIT_BOTH. The next state is a pure function of the two trackers' next values.
- WAIT_DMEM or WAIT_BOTH, unless `dmem_resp` this cycle (data freeze):
  - Assert all four stalls.
  - `bubble_ex` = 0, `flush_id` = 0.
- WAIT_IMEM, unless `imem_resp` this cycle:
  - Assert `stall_if` and `stall_id`, and `bubble_ex` = 1.
  - EX/MEM/WB keep advancing.
- Load-use:
  - Condition: `ex_is_load`, `ex_rd_s` != 0, and it matches a used `id_rs*_s`.
  - Response: `stall_if` = `stall_id` = 1 and `bubble_ex` = 1 for one cycle.
- Redirect (`ex_br_taken`, no data freeze):
  - Assert `flush_id` = 1 and `bubble_ex` = 1. Load-use is suppressed.
  - If imem is outstanding and no `imem_resp` arrives this cycle, set `drop_pending`.
  - If imem is outstanding and `imem_resp` arrives this cycle, assert `imem_discard` that cycle.
- `drop_pending` set: the next `imem_resp` gets `imem_discard` = 1 and clears `drop_pending`. The IMEM stall continues until a non-discarded response arrives.
- Priority: data freeze > redirect > IMEM wait > load-use.
- Watchdog:
  - Counter increments each cycle the state is not IDLE and clears in IDLE.
  - When the count reaches TIMEOUT_CYCLES, `timeout_err` sets and holds until reset.
  - The counter saturates.

## Timing
- All stall, bubble, flush and discard outputs are combinational from the registered state plus this-cycle inputs, so they take effect on the same clock edge.
- The trackers, FSM, `drop_pending`, watchdog and perf counters are registered.
- Reset values:
  - State IDLE; trackers 0; `drop_pending` 0.
  - `timeout_err` 0; counters 0.
  - All stalls, bubbles and flushes 0, given idle inputs.
- Load-use costs exactly 1 bubble. The following cycle the load is in MEM and is served by forwarding.
- Asserting `rst` mid-wait aborts the wait immediately. A late response after reset is ignored by the trackers.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cnt` counts cycles with `stall_if` = 1.
  - `perf_loaduse_cnt` counts load-use bubbles.
  - Both are 32-bit, wrap on overflow, and reset to 0.
- Not defined: the ports and counters are absent. No other behaviour differs.

## Structure
- `rv32i_types` gains `pipe_ctrl_state_t` (IDLE, WAIT_IMEM, WAIT_DMEM, WAIT_BOTH).
- Sub-module `mem_outstanding_tracker` (req/resp/outstanding flag), instantiated twice.

## Test plan
- ID reads x5 with rs1_used=1, EX is a load with rd=x5 -> one cycle of `stall_if` = `stall_id` = `bubble_ex` = 1. Repeat with rd=x0 -> no stall.
- `dmem_req` at cycle 10, `dmem_resp` at cycle 14 -> all stalls high in cycles 11–13, low in cycle 14.
- `imem_req` at cycle 0, `ex_br_taken` at cycle 1, `imem_resp` at cycle 3 -> `flush_id` at 1, `imem_discard` at 3, IF still stalled until the next non-discarded `imem_resp`.
- Load-use while in WAIT_DMEM -> freeze only, `bubble_ex` = 0, `perf_loaduse_cnt` unchanged.
- TIMEOUT_CYCLES=8, `dmem_resp` withheld -> `timeout_err` = 1 after 8 WAIT cycles and stays 1 after the response arrives.
- `rst` asserted mid-WAIT_BOTH -> outputs 0 asynchronously. A subsequent stray `imem_resp` produces no stall and no discard.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types; here the state encoding of the pipeline stall/flush controller.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IMEM = 2'd1,
        WAIT_DMEM = 2'd2,
        WAIT_BOTH = 2'd3
    } pipe_ctrl_state_t;

    function automatic pipe_ctrl_state_t pipe_ctrl_state_of(input logic imem_busy, input logic dmem_busy);
        case ({imem_busy, dmem_busy})
            2'b10:   return WAIT_IMEM;
            2'b01:   return WAIT_DMEM;
            2'b11:   return WAIT_BOTH;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_ctrl_tracker.sv
// Single outstanding-request flag for one memory port: set on req, cleared on resp.
module mem_outstanding_tracker (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic resp,
    output logic outstanding,
    output logic outstanding_next
);

    logic outstanding_reg;

    // A req in the same cycle as a resp is a new request, so the flag stays set.
    always_comb outstanding_next = req | (outstanding_reg & ~resp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) outstanding_reg <= 1'b0;
        else     outstanding_reg <= outstanding_next;
    end

    assign outstanding = outstanding_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_s,
    input  logic [4:0]  id_rs2_s,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd_s,
    input  logic        ex_is_load,
    input  logic        ex_br_taken,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        imem_discard,
    output logic        timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_loaduse_cnt
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    pipe_ctrl_state_t state_reg, state_next;
    logic             imem_busy, imem_busy_next;
    logic             dmem_busy, dmem_busy_next;
    logic             drop_pending_reg, drop_pending_next;
    logic [CW-1:0]    wd_cnt_reg, wd_cnt_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             data_freeze, redirect, imem_wait, load_use, loaduse_bubble;

    mem_outstanding_tracker u_imem_trk (
        .clk              (clk),
        .rst              (rst),
        .req              (imem_req),
        .resp             (imem_resp),
        .outstanding      (imem_busy),
        .outstanding_next (imem_busy_next)
    );

    mem_outstanding_tracker u_dmem_trk (
        .clk              (clk),
        .rst              (rst),
        .req              (dmem_req),
        .resp             (dmem_resp),
        .outstanding      (dmem_busy),
        .outstanding_next (dmem_busy_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            drop_pending_reg <= 1'b0;
            wd_cnt_reg       <= '0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            drop_pending_reg <= drop_pending_next;
            wd_cnt_reg       <= wd_cnt_next;
            timeout_err_reg  <= timeout_err_next;
        end
    end

    always_comb begin
        state_next        = pipe_ctrl_state_of(imem_busy_next, dmem_busy_next);
        stall_if          = 1'b0;
        stall_id          = 1'b0;
        stall_ex          = 1'b0;
        stall_mem         = 1'b0;
        bubble_ex         = 1'b0;
        flush_id          = 1'b0;
        imem_discard      = 1'b0;
        loaduse_bubble    = 1'b0;
        drop_pending_next = drop_pending_reg;

        data_freeze = (state_reg == WAIT_DMEM || state_reg == WAIT_BOTH) && !dmem_resp;
        redirect    = ex_br_taken && !data_freeze;
        load_use    = ex_is_load && (ex_rd_s != 5'd0) &&
                      ((id_rs1_used && (id_rs1_s == ex_rd_s)) ||
                       (id_rs2_used && (id_rs2_s == ex_rd_s)));

        // A fetch already in flight when a redirect resolves belongs to the wrong path.
        if (imem_busy && imem_resp && (drop_pending_reg || redirect))
            imem_discard = 1'b1;
        if (imem_discard)
            drop_pending_next = 1'b0;
        else if (redirect && imem_busy && !imem_resp)
            drop_pending_next = 1'b1;

        // A discarded response does not end the fetch wait.
        imem_wait = (state_reg == WAIT_IMEM || state_reg == WAIT_BOTH) &&
                    !(imem_resp && !imem_discard);

        if (data_freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (imem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use) begin
            stall_if       = 1'b1;
            stall_id       = 1'b1;
            bubble_ex      = 1'b1;
            loaduse_bubble = 1'b1;
        end

        if (state_reg == IDLE)    wd_cnt_next = '0;
        else if (wd_cnt_reg == TMAX) wd_cnt_next = wd_cnt_reg;
        else                      wd_cnt_next = wd_cnt_reg + 1'b1;
        timeout_err_next = timeout_err_reg | ((TIMEOUT_CYCLES != 0) && (wd_cnt_next == TMAX));
    end

    assign timeout_err = timeout_err_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_reg, perf_loaduse_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_reg   <= '0;
            perf_loaduse_cnt_reg <= '0;
        end else begin
            perf_stall_cnt_reg   <= perf_stall_cnt_reg + {31'd0, stall_if};
            perf_loaduse_cnt_reg <= perf_loaduse_cnt_reg + {31'd0, loaduse_bubble};
        end
    end

    assign perf_stall_cnt   = perf_stall_cnt_reg;
    assign perf_loaduse_cnt = perf_loaduse_cnt_reg;
`endif

endmodule
